rggen_host_arbiter: RTL

Round-robin arbiter that shares one register-block local bus among several host-side requesters. Each requester presents a command, write/read, address, write data and write mask. The arbiter forwards one command at a time to the response mux and address decoders, and routes the response back to the granted requester. A response timeout guarantees forward progress when no register answers.

---
 rtl/rggen_host_arbiter_pkg.sv | 19 +
 rtl/rggen_round_robin_selector.sv | 39 +++
 rtl/rggen_host_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/rggen_host_arbiter_pkg.sv
// rggen_host_arbiter_pkg: shared state encoding, response status codes and timeout counter sizing.
package rggen_host_arbiter_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } rggen_arbiter_state_e;

    localparam logic [1:0] RGGEN_STATUS_OKAY   = 2'b00;
    localparam logic [1:0] RGGEN_STATUS_SLVERR = 2'b10;

    // Counter wide enough to hold TIMEOUT_CYCLES, kept within 8..32 bits.
    function automatic int rggen_timeout_width(int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 8) ? 8 : (w > 32) ? 32 : w;
    endfunction

endpackage

// File: rtl/rggen_round_robin_selector.sv
// rggen_round_robin_selector: round-robin priority pointer and one-hot grant for the host arbiter.
module rggen_round_robin_selector #(
    parameter int REQUESTERS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REQUESTERS-1:0] request_i,
    input  logic                  update_i,
    output logic [REQUESTERS-1:0] grant_o
);

    localparam int PW = $clog2(REQUESTERS);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic [PW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx     = '0;
        cand    = '0;
        // Walk from lowest to highest priority so the highest-priority request is written last.
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr_q) + k) % REQUESTERS);
            if (request_i[cand]) idx = cand;
        end
        if (|request_i) grant_o[idx] = 1'b1;
        ptr_d = (update_i && |request_i)
              ? ((int'(idx) == REQUESTERS - 1) ? '0 : idx + 1'b1)
              : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rggen_host_arbiter.sv
// rggen_host_arbiter: round-robin sharing of one register-block local bus among several hosts,
// with response routing back to the granted host and a response timeout for forward progress.
module rggen_host_arbiter
    import rggen_host_arbiter_pkg::*;
#(
    parameter int REQUESTERS          = 2,
    parameter int DATA_WIDTH          = 32,
    parameter int LOCAL_ADDRESS_WIDTH = 8,
    parameter int TIMEOUT_CYCLES      = 64
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic [REQUESTERS-1:0]                          i_command_valid,
    input  logic [REQUESTERS-1:0]                          i_write,
    input  logic [REQUESTERS-1:0]                          i_read,
    input  logic [REQUESTERS-1:0][LOCAL_ADDRESS_WIDTH-1:0] i_address,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]          i_write_data,
    input  logic [REQUESTERS-1:0][DATA_WIDTH-1:0]          i_write_mask,
    output logic [REQUESTERS-1:0]                          o_response_ready,
    output logic [DATA_WIDTH-1:0]                          o_read_data,
    output logic [1:0]                                     o_status,
    output logic                                           o_command_valid,
    output logic                                           o_write,
    output logic                                           o_read,
    output logic [LOCAL_ADDRESS_WIDTH-1:0]                 o_address,
    output logic [DATA_WIDTH-1:0]                          o_write_data,
    output logic [DATA_WIDTH-1:0]                          o_write_mask,
    input  logic                                           i_response_ready,
    input  logic [DATA_WIDTH-1:0]                          i_read_data,
    input  logic [1:0]                                     i_status
);

    localparam int CW = rggen_timeout_width(TIMEOUT_CYCLES);

    rggen_arbiter_state_e state_q, state_d;

    logic [REQUESTERS-1:0]          grant;
    logic [REQUESTERS-1:0]          grant_q, grant_d;
    logic                           write_q, write_d;
    logic                           read_q, read_d;
    logic [LOCAL_ADDRESS_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0]          wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]          wmask_q, wmask_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           start;
    logic                           timeout;
    logic                           bus_rsp;
    logic                           done;

    assign start = (state_q == IDLE) && |i_command_valid;

    rggen_round_robin_selector #(
        .REQUESTERS (REQUESTERS)
    ) u_selector (
        .clk       (clk),
        .rst       (rst),
        .request_i (i_command_valid),
        .update_i  (start),
        .grant_o   (grant)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        write_d   = write_q;
        read_d    = read_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        cnt_d     = '0;
        timeout   = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
        // A reset cycle abandons the command, so it must not produce a response pulse.
        bus_rsp   = (state_q == BUSY) && !rst && i_response_ready;
        done      = (state_q == BUSY) && !rst && (i_response_ready || timeout);
        if (start) begin
            state_d = BUSY;
            grant_d = grant;
            write_d = |(i_write & grant);
            read_d  = |(i_read & grant);
            for (int r = 0; r < REQUESTERS; r++) begin
                if (grant[r]) begin
                    address_d = i_address[r];
                    wdata_d   = i_write_data[r];
                    wmask_d   = i_write_mask[r];
                end
            end
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = done ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            wmask_q   <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            write_q   <= write_d;
            read_q    <= read_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            wmask_q   <= wmask_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_command_valid  = (state_q == BUSY);
    assign o_write          = write_q;
    assign o_read           = read_q;
    assign o_address        = address_q;
    assign o_write_data     = wdata_q;
    assign o_write_mask     = wmask_q;
    assign o_response_ready = done ? grant_q : '0;
    assign o_read_data      = bus_rsp ? i_read_data : '0;
    assign o_status         = bus_rsp ? i_status : done ? RGGEN_STATUS_SLVERR : RGGEN_STATUS_OKAY;

endmodule
